// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobing, row debounce, and a two-digit
// hex entry shift register feeding the calculator datapath.
module keypad_scan #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DEB_CNT  = 10
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       key_clr,
   input  logic [3:0] key_r,
   output logic [3:0] key_c,
   output logic [7:0] key_out,
   output logic [3:0] key_code,
   output logic       key_valid
);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_e;

   state_e      state_q, state_d;
   logic [3:0]  r_meta_q, rs_q;
   logic [15:0] div_q;
   logic        tick;
   logic [1:0]  col_q, col_d;
   logic [1:0]  row_q, row_d;
   logic [3:0]  pat_q, pat_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  low_row;
   logic        accept;
   logic [3:0]  code;
   logic [7:0]  key_out_q;
   logic [3:0]  key_code_q;
   logic        key_valid_q;

   assign tick = (div_q == 16'(SCAN_DIV - 1));
   assign code = {row_q, col_q};

   // Lowest-numbered active row wins when several rows are pulled low.
   always_comb begin
      low_row = 2'd3;
      if (!rs_q[2]) low_row = 2'd2;
      if (!rs_q[1]) low_row = 2'd1;
      if (!rs_q[0]) low_row = 2'd0;
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      row_d   = row_q;
      accept  = 1'b0;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (rs_q == 4'hF) begin
                  col_d = col_q + 2'd1;
               end else begin
                  pat_d   = rs_q;
                  row_d   = low_row;
                  cnt_d   = 8'd0;
                  state_d = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (rs_q == pat_q) begin
                  if (cnt_q == 8'(DEB_CNT - 1)) begin
                     accept  = 1'b1;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end else begin
                  state_d = SCAN;
                  col_d   = col_q + 2'd1;
               end
            end
            HOLD: begin
               if (rs_q == 4'hF) begin
                  cnt_d   = 8'd0;
                  state_d = RELEASE;
               end
            end
            RELEASE: begin
               if (rs_q != 4'hF) begin
                  state_d = HOLD;
               end else if (cnt_q == 8'(DEB_CNT - 1)) begin
                  state_d = SCAN;
                  col_d   = col_q + 2'd1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_meta_q    <= 4'hF;
         rs_q        <= 4'hF;
         div_q       <= 16'd0;
         state_q     <= SCAN;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         pat_q       <= 4'hF;
         cnt_q       <= 8'd0;
         key_out_q   <= 8'h00;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
      end else begin
         r_meta_q    <= key_r;
         rs_q        <= r_meta_q;
         div_q       <= tick ? 16'd0 : div_q + 16'd1;
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         pat_q       <= pat_d;
         cnt_q       <= cnt_d;
         key_valid_q <= accept;
         // A clear landing on the accept cycle keeps only the new digit.
         if (accept) begin
            key_code_q <= code;
            key_out_q  <= key_clr ? {4'h0, code} : {key_out_q[3:0], code};
         end else if (key_clr) begin
            key_out_q  <= 8'h00;
         end
      end
   end

   assign key_c     = ~(4'b1000 >> col_q);
   assign key_out   = key_out_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model answers the column strobe,
// expected accepts are queued by the stimulus and checked by a monitor.
module tb_keypad_scan;

   logic       clk = 1'b0;
   logic       clr;
   logic       key_clr;
   logic [3:0] key_r;
   logic [3:0] key_c;
   logic [7:0] key_out;
   logic [3:0] key_code;
   logic       key_valid;

   logic       press_en, ovr_en;
   logic [1:0] press_row, press_col;
   logic [3:0] ovr_r;

   typedef struct packed {
      logic [3:0] code;
      logic [7:0] out;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   keypad_scan #(.SCAN_DIV(4), .DEB_CNT(3)) dut (
      .clk(clk), .clr(clr), .key_clr(key_clr), .key_r(key_r),
      .key_c(key_c), .key_out(key_out), .key_code(key_code), .key_valid(key_valid)
   );

   always #5 clk = ~clk;

   // Matrix model: the pressed key pulls its row low only while its column is strobed.
   assign key_r = ovr_en ? ovr_r :
                  (press_en && key_c == ~(4'b1000 >> press_col)) ? ~(4'b0001 << press_row) : 4'hF;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (key_valid) begin
         pulses++;
         if (exp_q.size() == 0) begin
            chk("unexpected_key_valid", {28'd0, key_code}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("key_code", {28'd0, key_code}, {28'd0, e.code});
            chk("key_out", {24'd0, key_out}, {24'd0, e.out});
         end
      end
   end

   task automatic ticks(input int n);
      repeat (n * 4) @(negedge clk);
   endtask

   task automatic press(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code,
                        input logic [7:0] out);
      exp_t e;
      e.code = code;
      e.out  = out;
      exp_q.push_back(e);
      press_row = r;
      press_col = c;
      press_en  = 1'b1;
      ticks(20);
      press_en = 1'b0;
      ticks(8);
   endtask

   task automatic wait_valid(input int bound);
      bit seen = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (key_valid) seen = 1;
      end
      if (!seen) chk("wait_key_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_clr();
      key_clr = 1'b1;
      @(negedge clk);
      key_clr = 1'b0;
   endtask

   initial begin
      logic [3:0] k0;
      exp_t e;
      clr = 1'b0; key_clr = 1'b0; press_en = 1'b0; ovr_en = 1'b0;
      press_row = 2'd0; press_col = 2'd0; ovr_r = 4'hF;
      repeat (3) @(negedge clk);
      chk("rst_key_c", {28'd0, key_c}, 32'h7);
      chk("rst_key_out", {24'd0, key_out}, 32'h0);
      chk("rst_key_code", {28'd0, key_code}, 32'h0);
      chk("rst_key_valid", {31'd0, key_valid}, 32'h0);
      clr = 1'b1;

      // Idle: column index advances once per 4 clocks.
      for (int i = 0; i < 40; i++) begin
         logic [1:0] c;
         @(negedge clk);
         c = 2'(((i + 1) / 4) % 4);
         chk("idle_key_c", {28'd0, key_c}, {28'd0, ~(4'b1000 >> c)});
      end

      press(2'd2, 2'd2, 4'hA, 8'h0A);
      chk("after_A_code", {28'd0, key_code}, 32'hA);
      pulse_clr();
      chk("clr_out_00", {24'd0, key_out}, 32'h00);
      chk("clr_keeps_code", {28'd0, key_code}, 32'hA);

      press(2'd0, 2'd3, 4'h3, 8'h03);
      press(2'd1, 2'd3, 4'h7, 8'h37);
      chk("two_press_out", {24'd0, key_out}, 32'h37);
      pulse_clr();
      chk("clr_37_to_00", {24'd0, key_out}, 32'h00);
      chk("clr_keeps_code7", {28'd0, key_code}, 32'h7);

      // key_clr held across the accept: the accept cycle must show only the new digit.
      key_clr = 1'b1;
      e.code = 4'h5; e.out = 8'h05;
      exp_q.push_back(e);
      press_row = 2'd1; press_col = 2'd1; press_en = 1'b1;
      wait_valid(200);
      key_clr = 1'b0;
      ticks(10);
      press_en = 1'b0;
      ticks(8);
      chk("clr_coincident_out", {24'd0, key_out}, 32'h05);

      // Bounce: row low for exactly one tick window at a time.
      ovr_r = 4'hE;
      repeat (5) begin
         ovr_en = 1'b1;
         repeat (4) @(negedge clk);
         ovr_en = 1'b0;
         repeat (4) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      k0 = key_c;
      repeat (4) @(negedge clk);
      chk("bounce_scan_adv1", {28'd0, key_c}, {28'd0, k0[0], k0[3:1]});
      k0 = key_c;
      repeat (4) @(negedge clk);
      chk("bounce_scan_adv2", {28'd0, key_c}, {28'd0, k0[0], k0[3:1]});

      // Reset abort mid-debounce, then re-accept of the still-held key.
      ovr_r = 4'h7;
      ovr_en = 1'b1;
      repeat (8) @(negedge clk);
      clr = 1'b0;
      #1;
      chk("abort_key_c", {28'd0, key_c}, 32'h7);
      chk("abort_key_out", {24'd0, key_out}, 32'h0);
      chk("abort_key_code", {28'd0, key_code}, 32'h0);
      chk("abort_key_valid", {31'd0, key_valid}, 32'h0);
      repeat (3) @(negedge clk);
      e.code = 4'hC; e.out = 8'h0C;
      exp_q.push_back(e);
      clr = 1'b1;
      wait_valid(100);
      ticks(10);
      ovr_en = 1'b0;
      ticks(8);

      chk("pending_expected", exp_q.size(), 32'd0);
      chk("valid_pulses", pulses, 32'd5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
